spi_peripheral_responder: RTL and testbench
===========================================

SPI_PERIPHERAL_RESPONDER -- requirements
Module: spi_peripheral_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning register address width carried in the header.
REQ-002 SHALL have parameter LEN_W, default 8, meaning word-count width carried in the header.
REQ-003 SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-004 SHALL have port S_AXI_ACLK, input, 1 bit: the single clock; spi_clk frequency is at most S_AXI_ACLK/8.
REQ-005 SHALL have port S_AXI_ARESET, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port spi_clk, input, 1 bit: SPI clock from the controller, asynchronous to S_AXI_ACLK.
REQ-007 SHALL have port cs_b, input, 1 bit: active-low frame select.
REQ-008 SHALL have port pico, input, 1 bit: controller-to-peripheral data.
REQ-009 SHALL have port poci, output, 1 bit: peripheral-to-controller data.
REQ-010 SHALL have port reg_addr, output, ADDR_W bits: register-bus address.
REQ-011 SHALL have port reg_wdata, output, DATA_W bits: register write data.
REQ-012 SHALL have port reg_we, output, 1 bit: one-cycle write strobe.
REQ-013 SHALL have port reg_re, output, 1 bit: one-cycle read strobe.
REQ-014 SHALL have port reg_rdata, input, DATA_W bits: read data, valid exactly one S_AXI_ACLK cycle after reg_re.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a complete frame ends.
REQ-016 SHALL have port frame_abort, output, 1 bit: one-cycle pulse when cs_b rises mid-frame.

Function
REQ-017 SHALL pass spi_clk, cs_b and pico through 2-flop synchronisers, then detect edges; the total detection latency from a pin edge is 3 S_AXI_ACLK cycles.
REQ-018 SHALL use SPI mode 0: pico is sampled on each rising spi_clk edge, and poci changes only on falling spi_clk edges or on the cs_b falling edge.
REQ-019 SHALL receive the frame header MSB first as 1+ADDR_W+LEN_W = 19 bits, in this order: rw (1 = read), address, word count N.
REQ-020 SHALL implement the states IDLE, HEADER, WRITE_DATA, READ_DATA and WAIT_CS.
- IDLE -> HEADER on the cs_b falling edge.
- HEADER -> WRITE_DATA or READ_DATA after bit 19, according to rw; -> WAIT_CS if N=0.
- Data states -> WAIT_CS after N words.
- WAIT_CS -> IDLE on the cs_b rising edge, with frame_done pulsed.
REQ-021 SHALL, in WRITE_DATA, after each 32nd sampled bit, assert reg_we for 1 cycle with the current address and the assembled word, then increment the address.
REQ-022 SHALL, in READ_DATA, assert reg_re one cycle after the rising edge that completes the header, and again after each completed word while words remain; reg_rdata is captured into a holding register.
REQ-023 SHALL load the holding register into the transmit shift register on the first falling edge after a word boundary, and shift left on all other falling edges; poci equals shift-register bit 31.
REQ-024 SHALL wrap the address from 2^ADDR_W-1 to 0 modulo 2^ADDR_W, with no error.
REQ-025 SHALL, on a cs_b rise in HEADER, WRITE_DATA or READ_DATA: discard any partial word, issue no reg_we for it, pulse frame_abort, and return to IDLE.
REQ-026 SHALL ignore spi_clk edges while cs_b is high and while in WAIT_CS.
REQ-027 SHALL drive poci to 0 whenever the state is not READ_DATA.
REQ-028 SHALL, when a cs_b rise and an spi_clk edge are detected in the same cycle, give priority to the cs_b rise.
REQ-029 SHALL never assert reg_we and reg_re in the same cycle.

Reset
REQ-030 SHALL, while S_AXI_ARESET is high, hold the state at IDLE, clear all counters, shift registers and synchronisers, and drive poci, reg_we, reg_re, frame_done, frame_abort, reg_addr and reg_wdata to 0.
REQ-031 SHALL, on reset release during an active frame (cs_b low), remain in IDLE until a new cs_b falling edge.

Structure
REQ-032 SHALL place the header field widths, the header bit count (19) and the state enum in the shared package spark_spi_pkg, which is also used by the controller-side block.
REQ-033 SHALL implement the synchronise-and-edge-detect logic in one sub-module, spi_pin_sync, instantiated once per input pin.

Verification
REQ-034 SHALL cover a single-word write: header rw=0, addr=0x005, N=1, data 0xDEADBEEF -> exactly one reg_we with addr 0x005 and data 0xDEADBEEF, then frame_done on cs_b rise.
REQ-035 SHALL cover a burst read: rw=1, addr=0x010, N=3, with the model returning 0x11111111/0x22222222/0x33333333 -> reg_re at addrs 0x010..0x012, and poci produces the three words MSB first.
REQ-036 SHALL cover address wrap: write with addr=0x3FF, N=2 -> reg_we at 0x3FF, then at 0x000.
REQ-037 SHALL cover abort: cs_b raised after 20 data bits of a write -> no reg_we, frame_abort pulse, IDLE.
REQ-038 SHALL cover a zero-length frame: N=0 -> no reg_we or reg_re, poci stays 0, frame_done on cs_b rise.
REQ-039 SHALL cover reset mid-frame: S_AXI_ARESET pulsed during a read -> all outputs 0, remaining spi_clk edges ignored until the next cs_b fall.

Source files
------------

// File: rtl/spark_spi_pkg.sv
// -----------------------------------------------------------------------------
// spark_spi_pkg
// Shared definitions for the SPARK SPI register-access protocol. Used by the
// peripheral-side responder and by the controller-side block.
//
// Contents:
//   SPI_ADDR_W / SPI_LEN_W / SPI_DATA_W : header field widths and data width
//   SPI_HDR_BITS                         : header length in bits (rw+addr+len)
//   spi_state_e                          : responder frame state
//   spi_dbg_t                            : debug snapshot of the responder FSM
// -----------------------------------------------------------------------------
package spark_spi_pkg;

    localparam int SPI_ADDR_W   = 10;
    localparam int SPI_LEN_W    = 8;
    localparam int SPI_DATA_W   = 32;
    localparam int SPI_HDR_BITS = 1 + SPI_ADDR_W + SPI_LEN_W;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HEADER     = 3'd1,
        ST_WRITE_DATA = 3'd2,
        ST_READ_DATA  = 3'd3,
        ST_WAIT_CS    = 3'd4
    } spi_state_e;

    // Snapshot of the responder FSM, visible hierarchically for checkers.
    typedef struct packed {
        spi_state_e state;
        logic       load_pending;
        logic       rd_capture;
    } spi_dbg_t;

endpackage

// File: rtl/spi_pin_sync.sv
// -----------------------------------------------------------------------------
// spi_pin_sync
// Brings one asynchronous SPI pin into the i_clk domain through a 2-flop
// synchroniser and produces registered edge pulses. An edge on i_pin shows up
// on o_rise/o_fall three i_clk cycles later; o_level is aligned with those
// pulses so a data pin sampled on another pin's edge pulse sees matching delay.
//
// Ports:
//   i_clk   : system clock
//   i_rst   : asynchronous active-high reset (clears all flops)
//   i_pin   : asynchronous input pin
//   o_level : synchronised level, aligned with the edge pulses
//   o_rise  : one-cycle pulse on a 0->1 transition
//   o_fall  : one-cycle pulse on a 1->0 transition
// -----------------------------------------------------------------------------
module spi_pin_sync
    import spark_spi_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_peripheral_responder.sv
// -----------------------------------------------------------------------------
// spi_peripheral_responder
// SPI mode-0 peripheral that turns framed SPI transfers into register-bus
// accesses. A frame (cs_b low) starts with a 1+ADDR_W+LEN_W bit header, MSB
// first: rw (1 = read), start address, word count N. Writes assemble DATA_W-bit
// words from pico and strobe reg_we; reads strobe reg_re, capture reg_rdata one
// cycle later and shift it out on poci MSB first. The address auto-increments
// per word and wraps modulo 2^ADDR_W. cs_b rising mid-frame aborts the frame.
//
// Valid/ready: there is no back-pressure on the register bus. reg_we / reg_re
// are single-cycle strobes qualified by reg_addr (and reg_wdata for writes);
// the bus must accept them unconditionally and return reg_rdata exactly one
// clock after reg_re.
//
// Ports:
//   S_AXI_ACLK   : system clock (spi_clk must be at most S_AXI_ACLK/8)
//   S_AXI_ARESET : asynchronous active-high reset
//   spi_clk      : SPI clock from controller (asynchronous)
//   cs_b         : active-low frame select (asynchronous)
//   pico         : controller-to-peripheral data (asynchronous)
//   poci         : peripheral-to-controller data, 0 outside READ_DATA
//   reg_addr     : register address
//   reg_wdata    : register write data
//   reg_we       : one-cycle write strobe
//   reg_re       : one-cycle read strobe
//   reg_rdata    : read data, valid one cycle after reg_re
//   frame_done   : one-cycle pulse when a complete frame ends
//   frame_abort  : one-cycle pulse when cs_b rises mid-frame
// -----------------------------------------------------------------------------
module spi_peripheral_responder
    import spark_spi_pkg::*;
#(
    parameter int ADDR_W = SPI_ADDR_W,
    parameter int LEN_W  = SPI_LEN_W,
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    input  logic              spi_clk,
    input  logic              cs_b,
    input  logic              pico,
    output logic              poci,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_done,
    output logic              frame_abort
);

    localparam int HDR_BITS = 1 + ADDR_W + LEN_W;
    localparam int CNT_MAX  = (HDR_BITS > DATA_W) ? HDR_BITS : DATA_W;
    localparam int CNT_W    = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

    // Synchronised pins and edge pulses
    logic w_sck_level;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_level;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_pico;
    logic w_pico_rise;
    logic w_pico_fall;

    spi_pin_sync u_sync_sck (
        .i_clk   (S_AXI_ACLK),
        .i_rst   (S_AXI_ARESET),
        .i_pin   (spi_clk),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_pin_sync u_sync_cs (
        .i_clk   (S_AXI_ACLK),
        .i_rst   (S_AXI_ARESET),
        .i_pin   (cs_b),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_pin_sync u_sync_pico (
        .i_clk   (S_AXI_ACLK),
        .i_rst   (S_AXI_ARESET),
        .i_pin   (pico),
        .o_level (w_pico),
        .o_rise  (w_pico_rise),
        .o_fall  (w_pico_fall)
    );

    // FSM and datapath registers
    spi_state_e          r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [HDR_BITS-2:0] r_hdr;
    logic [LEN_W-1:0]    r_words_left;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_hold;
    logic [DATA_W-1:0]   r_tx;
    logic                r_load_pending;
    logic                r_rd_capture;
    logic                r_we;
    logic                r_re;
    logic                r_done;
    logic                r_abort;

    // Header as it stands once the current pico bit is shifted in
    logic [HDR_BITS-1:0] w_hdr_full;
    logic                w_hdr_rw;
    logic [ADDR_W-1:0]   w_hdr_addr;
    logic [LEN_W-1:0]    w_hdr_len;
    logic [DATA_W-1:0]   w_rx_full;

    assign w_hdr_full = {r_hdr, w_pico};
    assign w_hdr_rw   = w_hdr_full[HDR_BITS-1];
    assign w_hdr_addr = w_hdr_full[LEN_W +: ADDR_W];
    assign w_hdr_len  = w_hdr_full[LEN_W-1:0];
    assign w_rx_full  = {r_rx[DATA_W-2:0], w_pico};

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= '0;
            r_hdr          <= '0;
            r_words_left   <= '0;
            r_addr         <= '0;
            r_rx           <= '0;
            r_wdata        <= '0;
            r_hold         <= '0;
            r_tx           <= '0;
            r_load_pending <= 1'b0;
            r_rd_capture   <= 1'b0;
            r_we           <= 1'b0;
            r_re           <= 1'b0;
            r_done         <= 1'b0;
            r_abort        <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_re         <= 1'b0;
            r_done       <= 1'b0;
            r_abort      <= 1'b0;
            r_rd_capture <= r_re;

            if (r_rd_capture) begin
                r_hold <= reg_rdata;
            end

            // A write strobe goes out with the current address; advance it
            // only afterwards so reg_addr is stable during reg_we.
            if (r_we) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state        <= ST_HEADER;
                        r_bit_cnt      <= '0;
                        r_hdr          <= '0;
                        r_tx           <= '0;
                        r_load_pending <= 1'b0;
                    end
                end

                ST_HEADER: begin
                    // cs_b rise wins over a simultaneous spi_clk edge
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                        r_abort <= 1'b1;
                    end else if (w_sck_rise) begin
                        r_hdr <= w_hdr_full[HDR_BITS-2:0];
                        if (r_bit_cnt == HDR_LAST) begin
                            r_bit_cnt    <= '0;
                            r_addr       <= w_hdr_addr;
                            r_words_left <= w_hdr_len;
                            if (w_hdr_len == '0) begin
                                r_state <= ST_WAIT_CS;
                            end else if (w_hdr_rw) begin
                                r_state        <= ST_READ_DATA;
                                r_re           <= 1'b1;
                                r_load_pending <= 1'b1;
                            end else begin
                                r_state <= ST_WRITE_DATA;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_WRITE_DATA: begin
                    // A partial word is simply dropped on abort
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                        r_abort <= 1'b1;
                    end else if (w_sck_rise) begin
                        r_rx <= w_rx_full;
                        if (r_bit_cnt == WORD_LAST) begin
                            r_bit_cnt    <= '0;
                            r_wdata      <= w_rx_full;
                            r_we         <= 1'b1;
                            r_words_left <= r_words_left - LEN_W'(1);
                            if (r_words_left == LEN_W'(1)) begin
                                r_state <= ST_WAIT_CS;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_READ_DATA: begin
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                        r_abort <= 1'b1;
                    end else begin
                        // First falling edge after a word boundary presents
                        // the freshly captured word; later ones shift it out.
                        if (w_sck_fall) begin
                            if (r_load_pending) begin
                                r_tx           <= r_hold;
                                r_load_pending <= 1'b0;
                            end else begin
                                r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                            end
                        end
                        if (w_sck_rise) begin
                            if (r_bit_cnt == WORD_LAST) begin
                                r_bit_cnt    <= '0;
                                r_words_left <= r_words_left - LEN_W'(1);
                                if (r_words_left == LEN_W'(1)) begin
                                    r_state <= ST_WAIT_CS;
                                end else begin
                                    r_addr         <= r_addr + ADDR_W'(1);
                                    r_re           <= 1'b1;
                                    r_load_pending <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                end

                ST_WAIT_CS: begin
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Debug snapshot of the FSM
    spi_dbg_t w_dbg;
    assign w_dbg = '{state: r_state, load_pending: r_load_pending, rd_capture: r_rd_capture};

    // Levels and pico edges are not needed by the FSM
    logic w_unused;
    assign w_unused = &{1'b0, w_sck_level, w_cs_level, w_pico_rise, w_pico_fall, w_dbg};

    assign poci        = (r_state == ST_READ_DATA) ? r_tx[DATA_W-1] : 1'b0;
    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;
    assign reg_we      = r_we;
    assign reg_re      = r_re;
    assign frame_done  = r_done;
    assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_peripheral_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_peripheral_responder
// Drives SPI mode-0 frames into spi_peripheral_responder and checks the
// register-bus traffic, poci data and frame_done/frame_abort pulses against a
// frame-level reference model (expected queues plus a reference memory).
// -----------------------------------------------------------------------------
module tb_spi_peripheral_responder;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst;
    logic        spi_clk;
    logic        cs_b;
    logic        pico;
    logic        poci;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic        frame_done;
    logic        frame_abort;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_peripheral_responder dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .spi_clk      (spi_clk),
        .cs_b         (cs_b),
        .pico         (pico),
        .poci         (poci),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort)
    );

    // ---------------- bookkeeping ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int hp           = 70;   // SPI half period, in clock-period tenths (10 per clk)

    int done_cnt     = 0;
    int abort_cnt    = 0;
    int overlap_cnt  = 0;
    int poci_hi_cnt  = 0;
    logic poci_quiet = 1'b0;

    logic [41:0] exp_we_q[$];   // {addr, data}
    logic [9:0]  exp_re_q[$];
    logic [41:0] mon_we;
    logic [9:0]  mon_re;

    logic [31:0] bus_mem[1024];  // register file seen by the DUT
    logic [31:0] ref_mem[1024];  // register file predicted by the model
    logic [31:0] wr_words[4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- register-bus responder ----------------
    always @(posedge clk) begin
        if (reg_we) bus_mem[reg_addr] = reg_wdata;
        if (reg_re) reg_rdata <= bus_mem[reg_addr];
        else        reg_rdata <= $urandom;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reg_we && reg_re) overlap_cnt++;
        if (frame_done)       done_cnt++;
        if (frame_abort)      abort_cnt++;
        if (poci_quiet && poci) poci_hi_cnt++;
        if (reg_we) begin
            chk("we_expected", 64'(exp_we_q.size() != 0), 64'(1));
            if (exp_we_q.size() != 0) begin
                mon_we = exp_we_q.pop_front();
                chk("we_addr", 64'(reg_addr), 64'(mon_we[41:32]));
                chk("we_data", 64'(reg_wdata), 64'(mon_we[31:0]));
            end
        end
        if (reg_re) begin
            chk("re_expected", 64'(exp_re_q.size() != 0), 64'(1));
            if (exp_re_q.size() != 0) begin
                mon_re = exp_re_q.pop_front();
                chk("re_addr", 64'(reg_addr), 64'(mon_re));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic spi_bit(input logic b, output logic s);
        pico = b;
        #(hp);
        s = poci;          // controller samples poci just before the rising edge
        spi_clk = 1'b1;
        #(hp);
        spi_clk = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_poci"},        64'(poci),        64'(0));
        chk({tag, "_reg_we"},      64'(reg_we),      64'(0));
        chk({tag, "_reg_re"},      64'(reg_re),      64'(0));
        chk({tag, "_frame_done"},  64'(frame_done),  64'(0));
        chk({tag, "_frame_abort"}, 64'(frame_abort), 64'(0));
        chk({tag, "_reg_addr"},    64'(reg_addr),    64'(0));
        chk({tag, "_reg_wdata"},   64'(reg_wdata),   64'(0));
    endtask

    task automatic check_frame_end(input int d_done, input int d_abort, input logic aborted);
        chk("we_left",   64'(exp_we_q.size()),     64'(0));
        chk("re_left",   64'(exp_re_q.size()),     64'(0));
        chk("done_cnt",  64'(done_cnt - d_done),   64'(aborted ? 0 : 1));
        chk("abort_cnt", 64'(abort_cnt - d_abort), 64'(aborted ? 1 : 0));
        chk("poci_zero", 64'(poci_hi_cnt),         64'(0));
        chk("we_re_overlap", 64'(overlap_cnt),     64'(0));
    endtask

    // One frame; stop_bits = number of spi_clk cycles before cs_b rises.
    task automatic spi_frame(input logic rw, input logic [9:0] addr, input logic [7:0] n,
                             input int stop_bits);
        int          total;
        int          nb;
        int          words;
        int          n_re;
        int          di;
        int          w;
        int          d_done;
        int          d_abort;
        logic        aborted;
        logic [18:0] hdr;
        logic        s;
        logic [31:0] rx_word;
        logic [9:0]  a;

        total   = 19 + 32 * int'(n);
        nb      = (stop_bits < total) ? stop_bits : total;
        aborted = (nb < total);
        words   = (nb >= 19) ? (nb - 19) / 32 : 0;

        // Reference model: what the register bus must see for this frame
        if (!rw) begin
            for (int i = 0; i < words; i++) begin
                a = addr + 10'(i);
                exp_we_q.push_back({a, wr_words[i]});
                ref_mem[a] = wr_words[i];
            end
        end else if (nb >= 19 && n != 0) begin
            n_re = (int'(n) < words + 1) ? int'(n) : words + 1;
            for (int i = 0; i < n_re; i++) exp_re_q.push_back(addr + 10'(i));
        end

        d_done      = done_cnt;
        d_abort     = abort_cnt;
        poci_hi_cnt = 0;
        rx_word     = '0;
        hdr         = {rw, addr, n};

        @(negedge clk);
        #3;
        poci_quiet = !rw;
        cs_b = 1'b0;
        #(hp);
        for (int i = 0; i < nb; i++) begin
            if (i < 19) begin
                spi_bit(hdr[18-i], s);
                if (s) poci_hi_cnt++;
            end else begin
                di = i - 19;
                w  = di / 32;
                if (!rw) begin
                    spi_bit(wr_words[w][31 - (di % 32)], s);
                end else begin
                    spi_bit(1'($urandom_range(0, 1)), s);
                    rx_word = {rx_word[30:0], s};
                    if (di % 32 == 31) begin
                        a = addr + 10'(w);
                        chk("rd_word", 64'(rx_word), 64'(ref_mem[a]));
                    end
                end
            end
        end
        #(hp);
        cs_b = 1'b1;
        repeat (12) @(negedge clk);
        poci_quiet = 1'b0;
        check_frame_end(d_done, d_abort, aborted);
    endtask

    // Read frame interrupted by a reset pulse; the rest of the frame is clocked
    // with cs_b still low and must be ignored.
    task automatic reset_mid_read();
        logic [18:0] hdr;
        logic        s;
        int          d_done;
        int          d_abort;

        hdr = {1'b1, 10'h100, 8'd2};
        exp_re_q.push_back(10'h100);
        d_done      = done_cnt;
        d_abort     = abort_cnt;
        poci_hi_cnt = 0;

        @(negedge clk);
        #3;
        cs_b = 1'b0;
        #(hp);
        for (int i = 0; i < 19; i++) spi_bit(hdr[18-i], s);
        for (int i = 0; i < 10; i++) spi_bit(1'($urandom_range(0, 1)), s);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        #3;
        poci_quiet = 1'b1;
        for (int i = 0; i < 54; i++) spi_bit(1'($urandom_range(0, 1)), s);
        #(hp);
        cs_b = 1'b1;
        repeat (12) @(negedge clk);
        poci_quiet = 1'b0;
        chk("rst_mid_done",  64'(done_cnt - d_done),   64'(0));
        chk("rst_mid_abort", 64'(abort_cnt - d_abort), 64'(0));
        chk("rst_mid_re",    64'(exp_re_q.size()),     64'(0));
        chk("rst_mid_we",    64'(exp_we_q.size()),     64'(0));
        chk("rst_mid_poci",  64'(poci_hi_cnt),         64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] v;
        logic        rw;
        logic [9:0]  addr;
        logic [7:0]  n;
        int          stop;

        rst     = 1'b1;
        spi_clk = 1'b0;
        cs_b    = 1'b1;
        pico    = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            bus_mem[i] = v;
            ref_mem[i] = v;
        end

        repeat (5) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Single-word write
        wr_words[0] = 32'hDEADBEEF;
        spi_frame(1'b0, 10'h005, 8'd1, 1000);

        // Burst read of three known words
        bus_mem[10'h010] = 32'h11111111; ref_mem[10'h010] = 32'h11111111;
        bus_mem[10'h011] = 32'h22222222; ref_mem[10'h011] = 32'h22222222;
        bus_mem[10'h012] = 32'h33333333; ref_mem[10'h012] = 32'h33333333;
        spi_frame(1'b1, 10'h010, 8'd3, 1000);

        // Address wrap on write, then read back across the wrap
        wr_words[0] = $urandom;
        wr_words[1] = $urandom;
        spi_frame(1'b0, 10'h3FF, 8'd2, 1000);
        spi_frame(1'b1, 10'h3FF, 8'd2, 1000);

        // Abort after 20 data bits of a write
        wr_words[0] = $urandom;
        spi_frame(1'b0, 10'h020, 8'd1, 19 + 20);

        // Zero-length frames
        spi_frame(1'b0, 10'h030, 8'd0, 1000);
        spi_frame(1'b1, 10'h031, 8'd0, 1000);

        // Reset in the middle of a read, then a clean frame afterwards
        reset_mid_read();
        wr_words[0] = $urandom;
        spi_frame(1'b0, 10'h040, 8'd1, 1000);
        spi_frame(1'b1, 10'h040, 8'd1, 1000);

        // Randomised frames: mixed direction, length, speed and aborts
        repeat (16) begin
            hp   = $urandom_range(6, 9) * 10;
            rw   = 1'($urandom_range(0, 1));
            addr = 10'($urandom);
            n    = 8'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) wr_words[i] = $urandom;
            if ($urandom_range(0, 3) == 0) stop = $urandom_range(1, 19 + 32 * int'(n));
            else                           stop = 1000;
            spi_frame(rw, addr, n, stop);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
